// File: rtl/mem_bus_ctrl.sv
// Bus controller between the 6502 memory request port and the external
// program ROM / work RAM: decode, setup phase, wait-stated strobe, one-cycle ack.
module mem_bus_ctrl #(
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned RAM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ack,
  output logic        err,
  output logic [15:0] rom_addr,
  output logic        rom_oe_n,
  input  logic [7:0]  rom_data,
  output logic [10:0] ram_addr,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  inout  logic [7:0]  ram_data
);

  localparam logic [3:0] ROM_CNT = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_CNT = 4'(RAM_WAIT);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t      state, state_nx;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        we_q, rom_q, ram_q, err_q;
  logic [3:0]  cnt;

  logic ram_hit, rom_hit, start;
  logic sel_rom, sel_ram, sel_we, sel_err;

  assign ram_hit = (addr[15:13] == 3'b000);
  assign rom_hit = addr[15];
  assign start   = (state == IDLE) && req;

  // Target attributes as they will be in the next cycle, so every strobe
  // can be registered from the next state without a combinational output path.
  always_comb begin
    sel_rom = rom_q;
    sel_ram = ram_q;
    sel_we  = we_q;
    sel_err = err_q;
    if (start) begin
      sel_rom = rom_hit;
      sel_ram = ram_hit;
      sel_we  = we;
      sel_err = !(ram_hit || (rom_hit && !we));
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = sel_err ? DONE : SETUP;
      SETUP:   state_nx = STROBE;
      STROBE:  if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rom_q    <= 1'b0;
      ram_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt      <= '0;
      rdata    <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      rom_oe_n <= 1'b1;
      ram_ce_n <= 1'b1;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
    end else begin
      state <= state_nx;

      if (start) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        we_q    <= we;
        rom_q   <= rom_hit;
        ram_q   <= ram_hit;
        err_q   <= sel_err;
      end

      if (state == SETUP)
        cnt <= sel_rom ? ROM_CNT : RAM_CNT;
      else if ((state == STROBE) && (cnt != '0))
        cnt <= cnt - 4'd1;

      if ((state == STROBE) && (cnt == '0) && !we_q)
        rdata <= rom_q ? rom_data : ram_data;
      else if (start && sel_err && !we)
        rdata <= 8'hFF;

      ack      <= (state_nx == DONE);
      err      <= (state_nx == DONE) && sel_err;
      rom_oe_n <= !((state_nx == STROBE) && sel_rom && !sel_we);
      // chip enable covers setup, strobe and the address-hold cycle
      ram_ce_n <= !(sel_ram && (state_nx != IDLE));
      ram_oe_n <= !((state_nx == STROBE) && sel_ram && !sel_we);
      ram_we_n <= !((state_nx == STROBE) && sel_ram && sel_we);
    end
  end

  assign rom_addr = addr_q;
  assign ram_addr = addr_q[10:0];
  assign ram_data = ram_we_n ? 'z : wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed cases plus random traffic
// against a transaction-level model of the ROM/RAM memory map.
module tb_mem_bus_ctrl;

  localparam int unsigned ROM_W = 1;
  localparam int unsigned RAM_W = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [15:0] addr;
  logic [7:0]  wdata, rdata;
  logic        ack, err;
  logic [15:0] rom_addr;
  logic        rom_oe_n;
  logic [7:0]  rom_data;
  logic [10:0] ram_addr;
  logic        ram_ce_n, ram_oe_n, ram_we_n;
  wire  [7:0]  ram_data;

  logic [7:0] rom     [0:32767];
  logic [7:0] ram_dev [0:2047];
  logic [7:0] exp_ram [0:2047];
  logic [7:0] exp_rdata;
  int total = 0;
  int bad   = 0;

  mem_bus_ctrl #(.ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .rom_addr(rom_addr), .rom_oe_n(rom_oe_n),
    .rom_data(rom_data), .ram_addr(ram_addr), .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // external memory devices
  assign rom_data = !rom_oe_n ? rom[rom_addr[14:0]] : 8'hxx;
  assign ram_data = (!ram_ce_n && !ram_oe_n) ? ram_dev[ram_addr] : 8'hzz;
  always @(posedge clk) if (!ram_ce_n && !ram_we_n) ram_dev[ram_addr] <= ram_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge with the controller idle; returns at the negedge after ack.
  task automatic txn(input logic w, input logic [15:0] a, input logic [7:0] d);
    logic        rom_t, ram_t, mapped, saw_ack, err_ack, both, err_stray;
    int unsigned wt, exp_ack, ack_c;
    int unsigned rom_lo, rom_first, ram_ce_lo, ram_oe_lo, ram_we_lo, ram_we_first;
    logic [7:0]  wr_seen;
    rom_t  = a[15];
    ram_t  = (a < 16'h2000);
    mapped = ram_t || (rom_t && !w);
    wt     = rom_t ? ROM_W : RAM_W;
    exp_ack = mapped ? 3 + wt : 1;
    if (!w) exp_rdata = !mapped ? 8'hFF : (rom_t ? rom[a[14:0]] : exp_ram[a % 2048]);
    if (ram_t && w) exp_ram[a % 2048] = d;

    saw_ack = 0; err_ack = 0; both = 0; err_stray = 0; ack_c = 0;
    rom_lo = 0; rom_first = 0; ram_ce_lo = 0; ram_oe_lo = 0; ram_we_lo = 0; ram_we_first = 0;
    wr_seen = 8'h00;
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    for (int c = 1; c <= 40 && !saw_ack; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
      if (!rom_oe_n) begin rom_lo++; if (rom_first == 0) rom_first = c; end
      if (!ram_ce_n) ram_ce_lo++;
      if (!ram_oe_n) ram_oe_lo++;
      if (!ram_we_n) begin
        ram_we_lo++; wr_seen = ram_data;
        if (ram_we_first == 0) ram_we_first = c;
      end
      if (!rom_oe_n && (!ram_we_n || !ram_oe_n)) both = 1;
      if (ack) begin saw_ack = 1; ack_c = c; err_ack = err; end
      else if (err) err_stray = 1;
    end
    check("ack_cycle", ack_c, exp_ack);
    check("err", err_ack, !mapped);
    check("err_stray", err_stray, 0);
    check("rdata", rdata, exp_rdata);
    check("rom_addr", rom_addr, a);
    check("ram_addr", ram_addr, a[10:0]);
    check("rom_oe_cnt", rom_lo, (rom_t && !w) ? wt + 1 : 0);
    check("rom_oe_first", rom_first, (rom_t && !w) ? 2 : 0);
    check("ram_ce_cnt", ram_ce_lo, ram_t ? wt + 3 : 0);
    check("ram_oe_cnt", ram_oe_lo, (ram_t && !w) ? wt + 1 : 0);
    check("ram_we_cnt", ram_we_lo, (ram_t && w) ? wt + 1 : 0);
    check("ram_we_first", ram_we_first, (ram_t && w) ? 2 : 0);
    check("strobe_excl", both, 0);
    if (ram_t && w) check("ram_wdata", wr_seen, d);
    @(negedge clk);
    check("ack_width", ack, 0);
  endtask

  logic [15:0] ra;
  logic        rw, cur_rom, ovl;
  int unsigned cyc, exp_cyc, k, acc;
  logic [7:0]  exp_b;

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < 32768; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) begin
      ram_dev[i] = 8'($urandom);
      exp_ram[i] = ram_dev[i];
    end
    rom[15'h7FFC] = 8'h34;
    exp_rdata = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", rdata, 8'h00);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_strobes", {rom_oe_n, ram_ce_n, ram_oe_n, ram_we_n}, 4'hF);
    check("rst_rom_addr", rom_addr, 16'h0000);
    check("rst_ram_addr", ram_addr, 11'h000);
    rst_n = 1'b1;
    @(negedge clk);

    txn(1'b0, 16'hFFFC, 8'h00);
    txn(1'b1, 16'h0805, 8'hA5);
    txn(1'b0, 16'h0005, 8'h00);
    txn(1'b1, 16'h9000, 8'h11);
    txn(1'b0, 16'h4016, 8'h00);

    // req held high: alternating ROM/RAM reads back to back
    cur_rom = 1'b1; ovl = 1'b0; k = 0; cyc = 0;
    addr = 16'h8000 | 16'($urandom_range(0, 32767)); we = 1'b0; req = 1'b1;
    exp_b = rom[addr[14:0]];
    exp_cyc = 3 + ROM_W;
    while (k < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!rom_oe_n && !ram_oe_n) ovl = 1'b1;
      if (ack || cyc == exp_cyc) begin
        check("b2b_ack_cycle", ack ? cyc : 0, exp_cyc);
        check("b2b_rdata", rdata, exp_b);
        check("b2b_err", err, 0);
        exp_rdata = exp_b;
        k++;
        cur_rom = !cur_rom;
        if (cur_rom) begin
          addr = 16'h8000 | 16'($urandom_range(0, 32767));
          exp_b = rom[addr[14:0]];
        end else begin
          addr = 16'($urandom_range(0, 16'h1FFF));
          exp_b = exp_ram[addr % 2048];
        end
        exp_cyc = cyc + 4 + (cur_rom ? ROM_W : RAM_W);
        if (k == 6) req = 1'b0;
      end
    end
    check("b2b_count", k, 6);
    check("b2b_oe_excl", ovl, 0);
    @(negedge clk);

    // reset during STROBE of a ROM read
    addr = 16'hC123; we = 1'b0; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("rst_pre_oe", rom_oe_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_strobes", {rom_oe_n, ram_ce_n, ram_oe_n, ram_we_n}, 4'hF);
    check("arst_ack", ack, 0);
    check("arst_rdata", rdata, 8'h00);
    exp_rdata = 8'h00;
    acc = 0;
    repeat (3) begin @(negedge clk); if (ack) acc++; end
    check("arst_no_ack", acc, 0);
    rst_n = 1'b1;
    @(negedge clk);
    txn(1'b0, 16'hC123, 8'h00);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: begin rw = 1'b0; ra = 16'h8000 | 16'($urandom_range(0, 32767)); end
        1, 2: begin
          rw = 1'($urandom);
          ra = 16'($urandom_range(0, 31)) | (16'($urandom_range(0, 3)) << 11);
        end
        3: begin rw = 1'($urandom); ra = 16'($urandom_range(16'h2000, 16'h7FFF)); end
        default: begin rw = 1'b1; ra = 16'h8000 | 16'($urandom_range(0, 32767)); end
      endcase
      txn(rw, ra, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Bus controller between the 6502 core's memory request port and the asynchronous external memories: the 32 KB program ROM and the 2 KB work RAM. It decodes each CPU request and drives the ROM's output-enable strobe (active-low) and the RAM's strobes with a setup phase and a programmable number of wait states. It samples read data into a register and returns a one-cycle acknowledge. Unmapped accesses and writes to ROM complete immediately with an error flag.

## Interface
- ROM_WAIT, 1: extra strobe cycles for ROM accesses (0..15).
- RAM_WAIT, 0: extra strobe cycles for RAM accesses (0..15).

- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  CPU request; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  16  CPU byte address; sampled with req.
- wdata  input  8  write data; sampled with req.
- rdata  output  8  registered read data; holds until the next completion.
- ack  output  1  one-cycle completion pulse.
- err  output  1  valid with ack; 1 = unmapped access or ROM write.
- rom_addr  output  16  ROM address; latched CPU address.
- rom_oe_n  output  1  ROM output enable, active-low.
- rom_data  input  8  ROM data bus; the ROM drives it only while rom_oe_n=0.
- ram_addr  output  11  RAM address = latched addr[10:0].
- ram_ce_n  output  1  RAM chip enable, active-low.
- ram_oe_n  output  1  RAM output enable, active-low.
- ram_we_n  output  1  RAM write enable, active-low.
- ram_data  inout  8  RAM data; driven with latched wdata only while ram_we_n=0, otherwise high-Z.

## Operation
- Address decode uses the latched addr:
  - 0x0000–0x1FFF → RAM. This is a 2 KB window mirrored four times.
  - 0x8000–0xFFFF → ROM.
  - All other addresses are unmapped.
- State machine has four states: IDLE, SETUP, STROBE, DONE.
- IDLE, req=1:
  - Latch addr, we and wdata; decode.
  - A mapped read, or a RAM write, goes to SETUP.
  - An unmapped access or a ROM write goes to DONE with err pending.
- SETUP: lasts one cycle. Addresses are stable. ram_ce_n=0 for RAM targets; all other strobes are high. Next state is STROBE.
- STROBE: lasts WAIT+1 cycles, where WAIT is ROM_WAIT or RAM_WAIT. A 4-bit down-counter is loaded on entry.
  - ROM read: rom_oe_n=0.
  - RAM read: ram_ce_n=0 and ram_oe_n=0.
  - RAM write: ram_ce_n=0, ram_we_n=0, ram_data driven.
  - Reads capture rom_data or ram_data into rdata on the final STROBE edge.
- DONE: lasts one cycle. ack=1 and err is valid. All strobes are high except ram_ce_n, which stays low for RAM targets as address hold. Next state is IDLE.
- Error completion:
  - Unmapped read: rdata=0xFF, err=1.
  - Unmapped write or ROM write: rdata unchanged, err=1, no strobe asserted.
- req outside IDLE is ignored. A req still high in the IDLE cycle after ack starts a new transaction.
- rom_oe_n and ram_we_n are never low in the same cycle. Only one device is strobed per transaction.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - rdata=0x00, ack=0, err=0.
  - rom_oe_n, ram_ce_n, ram_oe_n and ram_we_n all =1; ram_data high-Z.
  - rom_addr=0x0000, ram_addr=0x000.
- Reset mid-transaction aborts with no ack. After release the block starts in IDLE.
- Cycle 0 is the cycle in which req=1 is sampled in IDLE.
  - Mapped access: SETUP in cycle 1; STROBE in cycles 2..2+WAIT; ack in cycle 3+WAIT.
  - Defaults: ROM read ack in cycle 4, RAM access ack in cycle 3.
  - Error access: ack in cycle 1.
- Minimum spacing between ack pulses is WAIT+4 cycles for mapped accesses and 2 cycles for errors.
- All outputs are registered; no combinational path from req or addr to any output.

## Test plan
- Reset then ROM read at 0xFFFC, with the ROM model holding 0x34 there and ROM_WAIT=1 → rom_oe_n low in cycles 2–3, ack in cycle 4, rdata=0x34, err=0.
- RAM write 0x0805←0xA5 (a mirror address), then read 0x0005 → ram_addr=0x005 both times; ram_we_n low exactly in cycle 2; read returns 0xA5, ack in cycle 3.
- Write 0x9000←0x11 → ack in cycle 1, err=1; no ROM or RAM strobe ever asserted; rdata unchanged.
- Read 0x4016 (unmapped) → ack in cycle 1, err=1, rdata=0xFF.
- req held high for 20 cycles, alternating ROM and RAM reads → each ack is followed by a new SETUP in the next-but-one cycle; rom_oe_n and ram_oe_n are never low simultaneously.
- rst_n pulsed low during STROBE of a ROM read → all strobes high immediately, no ack, rdata=0x00; a subsequent ROM read completes normally.
